mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one slow 128-bit line memory between the instruction cache (read-only) and the data cache (read/write); replaces the two separate slow-memory ports at chip level.
- Sits between the two cache mem-side interfaces and the single memory port.
- Round-robin arbitration; one transaction in flight at a time.
- Registers the memory response (rdata/ready) before returning it to the granted cache, so no extra pipeline register is needed at the top.

Parameters:
ADDR_W, 28, line address width (byte address bits [31:4])
DATA_W, 128, line data width

Ports:
clk  input  1  system clock
proc_reset  input  1  synchronous active-high reset
i_mem_read  input  1  I-cache line read request, level, held until i_mem_ready
i_mem_write  input  1  I-cache write; ignored, never forwarded
i_mem_addr  input  ADDR_W  I-cache line address
i_mem_wdata  input  DATA_W  unused
i_mem_rdata  output  DATA_W  returned line to I-cache
i_mem_ready  output  1  one-cycle completion pulse to I-cache
d_mem_read  input  1  D-cache line read request, level
d_mem_write  input  1  D-cache line write request, level
d_mem_addr  input  ADDR_W  D-cache line address
d_mem_wdata  input  DATA_W  D-cache write line
d_mem_rdata  output  DATA_W  returned line to D-cache
d_mem_ready  output  1  one-cycle completion pulse to D-cache
mem_read  output  1  memory read strobe, level
mem_write  output  1  memory write strobe, level
mem_addr  output  ADDR_W  memory line address
mem_wdata  output  DATA_W  memory write line
mem_rdata  input  DATA_W  memory read line
mem_ready  input  1  memory completion, one-cycle pulse
grant_d  output  1  1 while the D-cache owns the memory (debug/testbed)

Behaviour:
- Reset (proc_reset high at a clk edge): state IDLE; all outputs 0 (mem_read, mem_write, mem_addr, mem_wdata, both ready pulses, both rdata, grant_d); last_served = I, so D wins the first tie.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Requests: req_i = i_mem_read; req_d = d_mem_read | d_mem_write.
  - Only one requester active: grant it.
  - Both active: grant the one not equal to last_served.
  - On grant, latch addr, wdata and op (d write has priority if d_mem_read & d_mem_write) into registers; set last_served; go to BUSY.
- BUSY:
  - mem_read/mem_write/mem_addr/mem_wdata are driven only from the latched registers; exactly one strobe is high.
  - Requester inputs are not re-sampled.
  - On mem_ready: deassert the strobe at the next edge; capture mem_rdata into the granted side's rdata register; pulse that side's ready for exactly one cycle; go to RESP.
- RESP: one cycle. Requests are ignored, because the served cache still holds its stale request this cycle. Go to IDLE.
- Latency:
  - Request seen in IDLE at cycle 0 -> memory strobe high from cycle 1.
  - mem_ready at cycle k -> cache ready and rdata valid at cycle k+1.
  - Earliest next grant decision is at cycle k+2.
- rdata registers hold their last captured value until the next capture for that side; ready of the non-granted side stays 0.
- Writes: on completion, d_mem_ready pulses and d_mem_rdata is also updated with mem_rdata (don't-care for the cache).
- I-side writes: i_mem_write is ignored entirely; an I request with only i_mem_write high is treated as no request.
- Request dropped while BUSY: the transaction still completes and the ready pulse is still issued.
- mem_ready while in IDLE or RESP: ignored.
- grant_d = 1 in BUSY/RESP when the D side is granted, else 0.
- Reset mid-transaction: immediate return to IDLE; strobes drop at that edge; no ready pulse is issued; last_served returns to I.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2), requester ids (REQ_I=1'b0, REQ_D=1'b1), ADDR_W/DATA_W defaults.
- One natural sub-module: rr_pick2, a combinational two-way round-robin picker (req_i, req_d, last_served -> gnt_valid, gnt_id).
- FSM, latches and response registers stay in mem_arbiter.

Test Plan:
- I-only read, addr 0x0000010, memory returns 0xDEAD..BEEF after 4 cycles -> mem_read high with mem_addr 0x0000010 from cycle 1; i_mem_ready pulses once with that data one cycle after mem_ready; d_mem_ready stays 0.
- D write, addr 0x0000020, wdata 0x1111..1111 -> mem_write high, mem_wdata 0x1111..1111, mem_read 0; d_mem_ready pulses once; grant_d 1 through RESP.
- I and D request simultaneously after reset -> D granted first (grant_d=1); I granted at cycle k+2 after D's mem_ready; I waits with no strobe overlap.
- Both requesters hold requests continuously for 4 transactions -> grants alternate D, I, D, I; exactly one strobe high at any time; exactly one ready pulse per transaction.
- i_mem_write=1 alone, then d_mem_read & d_mem_write both 1 -> first is ignored (mem strobes stay 0); second is issued as a write.
- proc_reset asserted in BUSY two cycles before mem_ready -> strobes 0 at the reset edge; no ready pulse; a following simultaneous request is granted to D first.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-cache line-memory arbiter: FSM encoding,
// requester ids and default widths.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the side
// that was not served last.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_served,
  output logic gnt_valid,
  output logic gnt_id
);

  assign gnt_valid = req_i | req_d;
  assign gnt_id    = (req_i & req_d) ? ~last_served : (req_d ? REQ_D : REQ_I);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line memory between the I-cache (reads only) and the D-cache
// (reads and writes); one transaction in flight, responses registered.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              grant_d
);

  arb_state_e        r_state;
  logic              r_last;
  logic              r_gnt_d;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_i_ready;
  logic              r_d_ready;

  logic w_req_i;
  logic w_req_d;
  logic w_gnt_valid;
  logic w_gnt_id;
  logic w_d_write;
  logic w_unused_i;

  // The I-cache never writes the line memory; its write side is dropped here.
  assign w_unused_i = i_mem_write ^ (^i_mem_wdata);
  assign w_req_i    = i_mem_read;
  assign w_req_d    = d_mem_read | d_mem_write;
  assign w_d_write  = (w_gnt_id == REQ_D) & d_mem_write;

  rr_pick2 u_pick (
    .req_i      (w_req_i),
    .req_d      (w_req_d),
    .last_served(r_last),
    .gnt_valid  (w_gnt_valid),
    .gnt_id     (w_gnt_id)
  );

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_state     <= ST_IDLE;
      r_last      <= REQ_I;
      r_gnt_d     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_ready   <= 1'b0;
      r_d_ready   <= 1'b0;
    end else begin
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            r_gnt_d     <= (w_gnt_id == REQ_D);
            r_last      <= w_gnt_id;
            r_addr      <= (w_gnt_id == REQ_D) ? d_mem_addr : i_mem_addr;
            r_wdata     <= (w_gnt_id == REQ_D) ? d_mem_wdata : '0;
            r_mem_write <= w_d_write;
            r_mem_read  <= ~w_d_write;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_gnt_d) begin
              r_d_rdata <= mem_rdata;
              r_d_ready <= 1'b1;
            end else begin
              r_i_rdata <= mem_rdata;
              r_i_ready <= 1'b1;
            end
            r_state <= ST_RESP;
          end
        end
        // The served cache still shows its old request here, so skip a cycle.
        ST_RESP: begin
          r_gnt_d <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign i_mem_rdata = r_i_rdata;
  assign d_mem_rdata = r_d_rdata;
  assign i_mem_ready = r_i_ready;
  assign d_mem_ready = r_d_ready;
  assign grant_d     = r_gnt_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand sequences for reset and
// alternation, then randomized cache/memory traffic against a timeline model.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          proc_reset;
  logic          i_mem_read, i_mem_write, d_mem_read, d_mem_write, mem_ready;
  logic [AW-1:0] i_mem_addr, d_mem_addr, mem_addr;
  logic [DW-1:0] i_mem_wdata, d_mem_wdata, mem_rdata, i_mem_rdata, d_mem_rdata, mem_wdata;
  logic          i_mem_ready, d_mem_ready, mem_read, mem_write, grant_d;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
    .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant_d(grant_d)
  );

  typedef struct {
    logic          ir, iw, dr, dw;
    logic [AW-1:0] iaddr, daddr;
    logic [DW-1:0] dwd, rdata;
    logic          exp_go, exp_gd, exp_wr;
  } vec_t;

  vec_t          vecs[8];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] i_hold, d_hold;

  // randomized-phase state
  int            cyc, free_from, mlat, ntx;
  logic          infl, infl_d, infl_wr, last_d;
  logic [AW-1:0] infl_addr;
  logic [DW-1:0] infl_wd;
  logic          ipend, dpend, idrop, ddrop, dr_op, dw_op;
  logic [AW-1:0] ia, da;
  logic [DW-1:0] dwd;
  logic          pi, pd, pdw, pmr;
  logic [AW-1:0] pia, pda;
  logic [DW-1:0] pdwd, pmrd;
  logic          e_rd, e_wr, e_gd, e_ir, e_dr;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chka(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_reqs();
    i_mem_read  = 1'b0;
    i_mem_write = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    drop_reqs();
    mem_ready = 1'b0;
    tick();
    proc_reset = 1'b0;
    i_hold = '0;
    d_hold = '0;
  endtask

  function automatic vec_t mkv(input logic ir, iw, dr, dw, input logic [AW-1:0] a_i, a_d,
                               input logic [DW-1:0] wd, rd, input logic go, gd, wr);
    vec_t v;
    v.ir = ir; v.iw = iw; v.dr = dr; v.dw = dw;
    v.iaddr = a_i; v.daddr = a_d; v.dwd = wd; v.rdata = rd;
    v.exp_go = go; v.exp_gd = gd; v.exp_wr = wr;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    i_mem_read  = v.ir;  i_mem_write = v.iw;
    d_mem_read  = v.dr;  d_mem_write = v.dw;
    i_mem_addr  = v.iaddr; d_mem_addr = v.daddr;
    d_mem_wdata = v.dwd; i_mem_wdata = ~v.dwd;
    tick();
    chk1("v_grant_d", grant_d, v.exp_go & v.exp_gd);
    chk1("v_mem_read", mem_read, v.exp_go & ~v.exp_wr);
    chk1("v_mem_write", mem_write, v.exp_go & v.exp_wr);
    if (v.exp_go) begin
      chka("v_mem_addr", mem_addr, v.exp_gd ? v.daddr : v.iaddr);
      if (v.exp_wr) chkd("v_mem_wdata", mem_wdata, v.dwd);
      for (int w = 0; w < 3; w++) begin
        tick();
        chk1("v_strobe_hold", v.exp_wr ? mem_write : mem_read, 1'b1);
        chk1("v_no_early_ready", i_mem_ready | d_mem_ready, 1'b0);
      end
      mem_ready = 1'b1;
      mem_rdata = v.rdata;
      tick();
      mem_ready = 1'b0;
      mem_rdata = {4{$urandom}};
      if (v.exp_gd) d_hold = v.rdata; else i_hold = v.rdata;
      chk1("v_strobe_drop", mem_read | mem_write, 1'b0);
      chk1("v_i_ready", i_mem_ready, ~v.exp_gd);
      chk1("v_d_ready", d_mem_ready, v.exp_gd);
      chkd("v_i_rdata", i_mem_rdata, i_hold);
      chkd("v_d_rdata", d_mem_rdata, d_hold);
      chk1("v_grant_d_resp", grant_d, v.exp_gd);
      drop_reqs();
      tick();
      chk1("v_ready_one_cycle", i_mem_ready | d_mem_ready, 1'b0);
      chk1("v_grant_d_idle", grant_d, 1'b0);
    end else begin
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk1("v_idle_strobes", mem_read | mem_write, 1'b0);
      chk1("v_idle_ready", i_mem_ready | d_mem_ready, 1'b0);
      chkd("v_idle_i_rdata", i_mem_rdata, i_hold);
      drop_reqs();
    end
  endtask

  initial begin
    logic          exp_d;
    logic [DW-1:0] rd;
    proc_reset = 1'b1;
    drop_reqs();
    mem_ready = 1'b0; mem_rdata = '0;
    i_mem_addr = '0; d_mem_addr = '0; i_mem_wdata = '0; d_mem_wdata = '0;

    vecs[0] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 28'h0000010, 28'h0000099, '0,
                  128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF, 1'b1, 1'b0, 1'b0);
    vecs[1] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 28'h0000000, 28'h0000020, {32{4'h1}},
                  {16{8'h5A}}, 1'b1, 1'b1, 1'b1);
    vecs[2] = mkv(1'b1, 1'b0, 1'b1, 1'b0, 28'h0000030, 28'h0000040, '0,
                  {4{32'h0BAD_F00D}}, 1'b1, 1'b0, 1'b0);
    vecs[3] = mkv(1'b1, 1'b0, 1'b1, 1'b1, 28'h0000050, 28'h0000060, {32{4'h2}},
                  {4{32'h1234_5678}}, 1'b1, 1'b1, 1'b1);
    vecs[4] = mkv(1'b0, 1'b1, 1'b0, 1'b0, 28'h0000070, 28'h0000000, '0,
                  '0, 1'b0, 1'b0, 1'b0);
    vecs[5] = mkv(1'b0, 1'b0, 1'b1, 1'b0, 28'h0000000, 28'h0000080, '0,
                  {4{32'hCAFE_0005}}, 1'b1, 1'b1, 1'b0);
    vecs[6] = mkv(1'b1, 1'b0, 1'b0, 1'b1, 28'h0000090, 28'h00000A0, {32{4'h3}},
                  {4{32'h6666_0006}}, 1'b1, 1'b0, 1'b0);
    vecs[7] = mkv(1'b1, 1'b0, 1'b1, 1'b0, 28'h00000B0, 28'h00000C0, '0,
                  {4{32'h7777_0007}}, 1'b1, 1'b1, 1'b0);

    // reset state
    tick();
    tick();
    proc_reset = 1'b0;
    i_hold = '0; d_hold = '0;
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chka("rst_mem_addr", mem_addr, '0);
    chkd("rst_mem_wdata", mem_wdata, '0);
    chk1("rst_ready", i_mem_ready | d_mem_ready, 1'b0);
    chkd("rst_i_rdata", i_mem_rdata, '0);
    chkd("rst_d_rdata", d_mem_rdata, '0);
    chk1("rst_grant_d", grant_d, 1'b0);

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // reset in the middle of a D transaction (last served is D here)
    d_mem_read = 1'b1; d_mem_addr = 28'h00000D0;
    tick();
    chk1("mr_grant_d", grant_d, 1'b1);
    chk1("mr_mem_read", mem_read, 1'b1);
    tick();
    proc_reset = 1'b1;
    tick();
    chk1("mr_strobe_drop", mem_read | mem_write, 1'b0);
    chk1("mr_grant_clear", grant_d, 1'b0);
    chk1("mr_no_ready", i_mem_ready | d_mem_ready, 1'b0);
    proc_reset = 1'b0;
    i_hold = '0; d_hold = '0;
    drop_reqs();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk1("mr_late_ready_ignored", i_mem_ready | d_mem_ready, 1'b0);
    chk1("mr_idle_strobes", mem_read | mem_write, 1'b0);
    chkd("mr_d_rdata_cleared", d_mem_rdata, d_hold);
    i_mem_read = 1'b1; i_mem_addr = 28'h00000E0; d_mem_read = 1'b1;
    tick();
    chk1("mr_tie_to_d", grant_d, 1'b1);
    chka("mr_tie_addr", mem_addr, 28'h00000D0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk1("mr_d_ready", d_mem_ready, 1'b1);
    drop_reqs();
    tick();

    // both caches hold requests across four transactions
    do_reset();
    i_mem_read = 1'b1; i_mem_addr = 28'h0000100;
    d_mem_read = 1'b1; d_mem_addr = 28'h0000200;
    for (int t = 0; t < 4; t++) begin
      exp_d = ((t % 2) == 0);
      tick();
      chk1("alt_grant_d", grant_d, exp_d);
      chk1("alt_mem_read", mem_read, 1'b1);
      chk1("alt_mem_write", mem_write, 1'b0);
      chka("alt_mem_addr", mem_addr, exp_d ? 28'h0000200 : 28'h0000100);
      mem_ready = 1'b1;
      rd = {4{$urandom}};
      mem_rdata = rd;
      tick();
      mem_ready = 1'b0;
      chk1("alt_no_overlap", mem_read | mem_write, 1'b0);
      chk1("alt_i_ready", i_mem_ready, ~exp_d);
      chk1("alt_d_ready", d_mem_ready, exp_d);
      chkd("alt_rdata", exp_d ? d_mem_rdata : i_mem_rdata, rd);
      tick();
      chk1("alt_ready_pulse", i_mem_ready | d_mem_ready, 1'b0);
    end
    drop_reqs();
    tick();

    // randomized traffic against a timeline model
    do_reset();
    infl = 1'b0; last_d = 1'b0; free_from = 0; cyc = 0; mlat = -1; ntx = 0;
    ipend = 1'b0; dpend = 1'b0; idrop = 1'b0; ddrop = 1'b0;
    dr_op = 1'b0; dw_op = 1'b0; ia = '0; da = '0; dwd = '0;
    infl_d = 1'b0; infl_wr = 1'b0; infl_addr = '0; infl_wd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!ipend && $urandom_range(0, 2) == 0) begin
        ipend = 1'b1;
        ia = AW'($urandom);
      end
      if (infl && !infl_d && $urandom_range(0, 3) == 0) idrop = 1'b1;
      i_mem_read  = ipend & ~idrop;
      i_mem_addr  = ia;
      i_mem_write = 1'($urandom_range(0, 1));
      i_mem_wdata = {4{$urandom}};
      if (!dpend && $urandom_range(0, 2) == 0) begin
        int r;
        r = $urandom_range(0, 2);
        dpend = 1'b1;
        da = AW'($urandom);
        dwd = {4{$urandom}};
        dr_op = (r != 1);
        dw_op = (r != 0);
      end
      if (infl && infl_d && $urandom_range(0, 3) == 0) ddrop = 1'b1;
      d_mem_read  = dpend & ~ddrop & dr_op;
      d_mem_write = dpend & ~ddrop & dw_op;
      d_mem_addr  = da;
      d_mem_wdata = dwd;
      mem_ready = 1'b0;
      mem_rdata = {4{$urandom}};
      if (infl) begin
        if (mlat == 0) begin
          mem_ready = 1'b1;
          mlat = -1;
        end else if (mlat > 0) begin
          mlat--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        mem_ready = 1'b1;
      end
      pi = i_mem_read; pd = d_mem_read | d_mem_write; pdw = d_mem_write;
      pia = i_mem_addr; pda = d_mem_addr; pdwd = d_mem_wdata;
      pmr = mem_ready; pmrd = mem_rdata;

      tick();
      cyc++;

      e_rd = 1'b0; e_wr = 1'b0; e_gd = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
      if (infl && pmr) begin
        e_ir = ~infl_d; e_dr = infl_d; e_gd = infl_d;
        if (infl_d) d_hold = pmrd; else i_hold = pmrd;
        infl = 1'b0;
        free_from = cyc + 1;
      end else if (infl) begin
        e_rd = ~infl_wr; e_wr = infl_wr; e_gd = infl_d;
      end else if ((cyc - 1) >= free_from && (pi | pd)) begin
        infl      = 1'b1;
        infl_d    = (pi & pd) ? ~last_d : pd;
        last_d    = infl_d;
        infl_wr   = infl_d & pdw;
        infl_addr = infl_d ? pda : pia;
        infl_wd   = pdwd;
        mlat      = $urandom_range(0, 3);
        ntx++;
        e_rd = ~infl_wr; e_wr = infl_wr; e_gd = infl_d;
      end
      chk1("r_mem_read", mem_read, e_rd);
      chk1("r_mem_write", mem_write, e_wr);
      chk1("r_grant_d", grant_d, e_gd);
      chk1("r_i_ready", i_mem_ready, e_ir);
      chk1("r_d_ready", d_mem_ready, e_dr);
      chkd("r_i_rdata", i_mem_rdata, i_hold);
      chkd("r_d_rdata", d_mem_rdata, d_hold);
      if (e_rd | e_wr) chka("r_mem_addr", mem_addr, infl_addr);
      if (e_wr) chkd("r_mem_wdata", mem_wdata, infl_wd);
      if (i_mem_ready) begin ipend = 1'b0; idrop = 1'b0; end
      if (d_mem_ready) begin dpend = 1'b0; ddrop = 1'b0; end
    end
    chk1("r_txn_progress", ntx > 100, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
